// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
// Three-aspect lamp sequencer (RED -> GREEN -> YELLOW) with programmable
// per-phase dwell counted in enabled ticks, and a pedestrian request path
// that can shorten GREEN and grants a walk interval on the next RED entry.

module traffic_phase_sequencer #(
    parameter int CNT_W        = 8,
    parameter int RED_TICKS    = 10,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int MIN_GREEN    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ped_req,
    output logic [2:0]       light,
    output logic             walk,
    output logic             ped_ack,
    output logic [CNT_W-1:0] phase_cnt
);

    typedef enum logic [1:0] {
        S_RED    = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(MIN_GREEN - 1);

    state_t           state;
    logic [CNT_W-1:0] elapsed;
    logic             pending;
    logic             req_seen;
    logic             state_legal;

    // A request present this cycle counts as pending so it can act on the same edge.
    assign req_seen    = pending | ped_req;
    assign state_legal = (state == S_RED) || (state == S_GREEN) || (state == S_YELLOW);
    assign phase_cnt   = elapsed;

    // Decode the one-hot lamp code from the phase; unknown encodings show RED.
    always_comb begin
        light = 3'b100;
        case (state)
            S_RED:    light = 3'b100;
            S_GREEN:  light = 3'b010;
            S_YELLOW: light = 3'b001;
            default:  light = 3'b100;
        endcase
    end

    // Phase state machine, dwell counter, request latch and walk/ack outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_RED;
            elapsed <= '0;
            pending <= 1'b0;
            walk    <= 1'b0;
            ped_ack <= 1'b0;
        end else begin
            ped_ack <= 1'b0;
            if (ped_req) begin
                pending <= 1'b1;
            end
            // Illegal encodings recover even while frozen.
            if (enable || !state_legal) begin
                case (state)
                    S_RED: begin
                        if (elapsed == RED_LAST) begin
                            state   <= S_GREEN;
                            elapsed <= '0;
                            walk    <= 1'b0;
                        end else begin
                            elapsed <= elapsed + CNT_W'(1);
                        end
                    end
                    S_GREEN: begin
                        if ((elapsed == GREEN_LAST) ||
                            (req_seen && (elapsed >= MIN_G_LAST))) begin
                            state   <= S_YELLOW;
                            elapsed <= '0;
                        end else begin
                            elapsed <= elapsed + CNT_W'(1);
                        end
                    end
                    S_YELLOW: begin
                        if (elapsed == YELLOW_LAST) begin
                            // Serving edge: a request arriving now is absorbed by this ack.
                            state   <= S_RED;
                            elapsed <= '0;
                            pending <= 1'b0;
                            walk    <= req_seen;
                            ped_ack <= req_seen;
                        end else begin
                            elapsed <= elapsed + CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= S_RED;
                        elapsed <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer
// Directed vector table for traffic_phase_sequencer with default parameters,
// plus a hand-written sequence for a held pedestrian request.

module tb_traffic_phase_sequencer;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    typedef struct {
        logic       rst;
        logic       en;
        logic       req;
        logic [2:0] light;
        logic       walk;
        logic       ack;
        logic [7:0] cnt;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       ped_req;
    logic [2:0] light;
    logic       walk;
    logic       ped_ack;
    logic [7:0] phase_cnt;

    int   checks;
    int   errors;
    vec_t vec[$];

    traffic_phase_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .ped_req  (ped_req),
        .light    (light),
        .walk     (walk),
        .ped_ack  (ped_ack),
        .phase_cnt(phase_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input int idx, input logic [2:0] l,
                         input logic w, input logic a, input logic [7:0] c);
        checks++;
        if ({light, walk, ped_ack, phase_cnt} !== {l, w, a, c}) begin
            errors++;
            $display("FAIL %s[%0d]: got light=%b walk=%b ack=%b cnt=%0d, expected light=%b walk=%b ack=%b cnt=%0d",
                     nm, idx, light, walk, ped_ack, phase_cnt, l, w, a, c);
        end
    endtask

    function automatic void add(input logic rs, input logic en, input logic rq,
                                input logic [2:0] l, input logic w, input logic a,
                                input int c);
        vec_t v;
        v.rst = rs; v.en = en; v.req = rq;
        v.light = l; v.walk = w; v.ack = a; v.cnt = 8'(c);
        vec.push_back(v);
    endfunction

    // Enabled, no-request edges whose post-edge count runs lo..hi in one phase.
    function automatic void run(input logic [2:0] l, input int lo, input int hi, input logic w);
        for (int k = lo; k <= hi; k++) add(1'b0, 1'b1, 1'b0, l, w, 1'b0, k);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int ack_at15;
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        ped_req = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_state", 0, R, 1'b0, 1'b0, 8'd0);

        // Vector rows: inputs applied before an edge, outputs expected after it.
        add(1'b1, 1'b0, 1'b0, R, 1'b0, 1'b0, 0);
        // Free-running cycle, no requests.
        run(R, 1, 9, 0); run(G, 0, 7, 0); run(Y, 0, 2, 0); add(0, 1, 0, R, 0, 0, 0);
        // Request on GREEN elapsed=0: two GREEN cycles, then served RED.
        run(R, 1, 9, 0); add(0, 1, 0, G, 0, 0, 0);
        add(0, 1, 1, G, 0, 0, 1); add(0, 1, 0, Y, 0, 0, 0); run(Y, 1, 2, 0);
        add(0, 1, 0, R, 1, 1, 0); run(R, 1, 9, 1); add(0, 1, 0, G, 0, 0, 0);
        run(G, 1, 7, 0); run(Y, 0, 2, 0); add(0, 1, 0, R, 0, 0, 0);
        // Request on GREEN elapsed=5: YELLOW on that edge.
        run(R, 1, 9, 0); run(G, 0, 5, 0); add(0, 1, 1, Y, 0, 0, 0); run(Y, 1, 2, 0);
        add(0, 1, 0, R, 1, 1, 0); run(R, 1, 9, 1); add(0, 1, 0, G, 0, 0, 0);
        // Freeze four cycles at YELLOW elapsed=1.
        run(G, 1, 7, 0); run(Y, 0, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, Y, 0, 0, 1);
        add(0, 1, 0, Y, 0, 0, 2); add(0, 1, 0, R, 0, 0, 0);
        // Request during RED with walk=0: served after the next short GREEN.
        add(0, 1, 1, R, 0, 0, 1); run(R, 2, 9, 0); add(0, 1, 0, G, 0, 0, 0);
        add(0, 1, 0, G, 0, 0, 1); add(0, 1, 0, Y, 0, 0, 0); run(Y, 1, 2, 0);
        add(0, 1, 0, R, 1, 1, 0);
        // Request during a walk RED: no mid-RED grant, served at next RED.
        run(R, 1, 3, 1); add(0, 1, 1, R, 1, 0, 4); run(R, 5, 9, 1);
        add(0, 1, 0, G, 0, 0, 0); add(0, 1, 0, G, 0, 0, 1); add(0, 1, 0, Y, 0, 0, 0);
        run(Y, 1, 2, 0); add(0, 1, 0, R, 1, 1, 0); run(R, 1, 9, 1); add(0, 1, 0, G, 0, 0, 0);
        // Request while frozen still latches.
        add(0, 0, 1, G, 0, 0, 0); add(0, 1, 0, G, 0, 0, 1); add(0, 1, 0, Y, 0, 0, 0);
        run(Y, 1, 2, 0); add(0, 1, 0, R, 1, 1, 0); run(R, 1, 9, 1); add(0, 1, 0, G, 0, 0, 0);
        // Reset mid-GREEN with a pending request: full cycle follows, no ack.
        add(0, 1, 1, G, 0, 0, 1); add(1, 1, 0, R, 0, 0, 0);
        run(R, 1, 9, 0); run(G, 0, 7, 0); run(Y, 0, 2, 0); add(0, 1, 0, R, 0, 0, 0);

        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clock);
            reset   = vec[i].rst;
            enable  = vec[i].en;
            ped_req = vec[i].req;
            if (vec[i].rst) begin
                #1 check("async_reset", i, R, 1'b0, 1'b0, 8'd0);
            end
            @(posedge clock);
            #1 check("vec", i, vec[i].light, vec[i].walk, vec[i].ack, vec[i].cnt);
        end

        // Held request from RED0: each 15-edge loop ends with exactly one ack.
        @(negedge clock);
        reset   = 1'b0;
        enable  = 1'b1;
        ped_req = 1'b1;
        acks     = 0;
        ack_at15 = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock);
            #1;
            if (ped_ack === 1'b1) begin
                acks++;
                if (e == 15) ack_at15 = 1;
            end
        end
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL held_req_ack_count: got %0d acks, expected 2", acks);
        end
        checks++;
        if (ack_at15 != 1) begin
            errors++;
            $display("FAIL held_req_ack_timing: ack at edge 15 got %0d, expected 1", ack_at15);
        end
        check("held_req_end", 30, R, 1'b1, 1'b1, 8'd0);

        @(negedge clock);
        ped_req = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
